input_debounce_sync: RTL and testbench

//  Upstream conditioning stage for the SOPC PIO inputs (BTN, SW[9:0]).

---
 rtl/input_debounce_sync.sv | 126 ++++++++++++
 tb/tb_input_debounce_sync.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/input_debounce_sync.sv
// input_debounce_sync
//   Conditions the raw board inputs (BTN on bit 0, SW[9:0] on bits 10:1)
//   before they reach the PIO ports. Each channel is handled independently:
//     1. A 2-flop synchroniser brings the pin into the CLOCK_50 domain.
//     2. A polarity fix-up maps it to a logical level (1 = asserted).
//     3. A stable counter must see the new level for STABLE_CYCLES
//        consecutive cycles before clean_out takes it.
//     4. One-cycle registered rise/fall pulses mark each accepted change.
//   Raw level held from edge t onward -> clean_out and the pulse change at
//   edge t+STABLE_CYCLES+2.
//
//   Optional feature, selected by macro DEBOUNCE_EVENT_LATCH_EN:
//     press_latched[i] is a sticky copy of rise_pulse[i], cleared by writing
//     latch_clr[i]=1. A rise arriving in the same cycle as the clear wins.
//     Without the macro, press_latched is tied to 0, latch_clr is ignored
//     and no latch flops exist.
//
//   No channel has a control FSM. The only per-channel state is the counter
//   and the accepted level, and both reset to 0.

module input_debounce_sync #(
  parameter int              N_CH            = 11,
  parameter int              STABLE_CYCLES   = 500000,
  parameter int              CNT_W           = 19,
  parameter logic [N_CH-1:0] ACTIVE_LOW_MASK = N_CH'(11'h001)
) (
  input  logic            CLOCK_50,
  input  logic            reset_n,
  input  logic [N_CH-1:0] raw_in,
  output logic [N_CH-1:0] clean_out,
  output logic [N_CH-1:0] rise_pulse,
  output logic [N_CH-1:0] fall_pulse,
  input  logic [N_CH-1:0] latch_clr,
  output logic [N_CH-1:0] press_latched
);

  // Final count value. Reaching it with the level still different from
  // clean_out accepts the change, so the counter never wraps.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  logic [N_CH-1:0] sync1;
  logic [N_CH-1:0] sync2;
  logic [N_CH-1:0] level;

  // The synchroniser samples the raw pins directly, so no logic sits in
  // front of the first flop. The reset value is each pin's idle level,
  // which is logical 0 after the polarity fix-up.
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= ACTIVE_LOW_MASK;
      sync2 <= ACTIVE_LOW_MASK;
    end else begin
      sync1 <= raw_in;
      sync2 <= sync1;
    end
  end

  // Logical level of each channel in the clock domain: 1 = asserted.
  assign level = sync2 ^ ACTIVE_LOW_MASK;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic [CNT_W-1:0] cnt;
    logic             clean_q;
    logic             rise_q;
    logic             fall_q;
    logic             differs;
    logic             accept;

    assign differs = (level[i] != clean_q);
    assign accept  = differs && (cnt == CNT_LAST);

    // Stable counter and accepted level. Any cycle in which the level
    // matches clean_out restarts qualification. The pulses are registered
    // and last only for the cycle in which clean_out shows the new level.
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
      if (!reset_n) begin
        cnt     <= '0;
        clean_q <= 1'b0;
        rise_q  <= 1'b0;
        fall_q  <= 1'b0;
      end else begin
        rise_q <= accept && level[i];
        fall_q <= accept && !level[i];
        if (!differs || accept) begin
          cnt <= '0;
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
        if (accept) begin
          clean_q <= level[i];
        end
      end
    end

    assign clean_out[i]  = clean_q;
    assign rise_pulse[i] = rise_q;
    assign fall_pulse[i] = fall_q;
  end

  // Each pulse is generated from the new level, so rise and fall on the
  // same channel exclude each other.
  a_no_rise_fall_overlap: assert property (
    @(posedge CLOCK_50) disable iff (!reset_n) ((rise_pulse & fall_pulse) == '0)
  );

`ifdef DEBOUNCE_EVENT_LATCH_EN
  logic [N_CH-1:0] press_q;

  // Sticky press capture. The OR with rise_pulse comes after the clear, so
  // a rise in the same cycle as a clear is kept.
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      press_q <= '0;
    end else begin
      press_q <= (press_q & ~latch_clr) | rise_pulse;
    end
  end

  assign press_latched = press_q;
`else
  logic unused_latch_clr;
  assign unused_latch_clr = ^latch_clr;
  assign press_latched    = '0;
`endif

endmodule

// File: tb/tb_input_debounce_sync.sv
// Directed testbench for input_debounce_sync with STABLE_CYCLES=4, N_CH=11,
// ACTIVE_LOW_MASK=11'h001. Inputs change 1 ns after a rising edge, and
// outputs are sampled at that same point. A raw change made after edge t
// therefore shows up on the outputs sampled after edge t+6.

module tb_input_debounce_sync;

  localparam int N_CH = 11;

  logic            clk;
  logic            reset_n;
  logic [N_CH-1:0] raw_in;
  logic [N_CH-1:0] latch_clr;
  logic [N_CH-1:0] clean_out;
  logic [N_CH-1:0] rise_pulse;
  logic [N_CH-1:0] fall_pulse;
  logic [N_CH-1:0] press_latched;

  int n_checks;
  int n_pass;

  // Expected per-cycle values, filled by expect_window and drained cycle by cycle.
  logic [N_CH-1:0] exp_rise_q[$];
  logic [N_CH-1:0] exp_fall_q[$];
  logic [N_CH-1:0] exp_clean_q[$];

  input_debounce_sync #(
    .N_CH            (N_CH),
    .STABLE_CYCLES   (4),
    .ACTIVE_LOW_MASK (11'h001)
  ) dut (
    .CLOCK_50      (clk),
    .reset_n       (reset_n),
    .raw_in        (raw_in),
    .clean_out     (clean_out),
    .rise_pulse    (rise_pulse),
    .fall_pulse    (fall_pulse),
    .latch_clr     (latch_clr),
    .press_latched (press_latched)
  );

  // Clock: 100 MHz is fine for the bench, because only cycle counts matter.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end else begin
      n_pass++;
    end
  endtask

  // Advance one clock edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Over the next n edges, expect one event at edge ev (1-based; 0 = none).
  // rise_pulse/fall_pulse carry rise_w/fall_w only at edge ev. clean_out is
  // clean_pre before edge ev and clean_post from edge ev onward.
  task automatic expect_window(input string tag, input int n, input int ev,
                               input logic [N_CH-1:0] rise_w, input logic [N_CH-1:0] fall_w,
                               input logic [N_CH-1:0] clean_pre,
                               input logic [N_CH-1:0] clean_post);
    logic [N_CH-1:0] e_r, e_f, e_c;
    for (int k = 1; k <= n; k++) begin
      exp_rise_q.push_back((k == ev) ? rise_w : '0);
      exp_fall_q.push_back((k == ev) ? fall_w : '0);
      exp_clean_q.push_back((ev != 0 && k >= ev) ? clean_post : clean_pre);
    end
    while (exp_rise_q.size() != 0) begin
      step();
      e_r = exp_rise_q.pop_front();
      e_f = exp_fall_q.pop_front();
      e_c = exp_clean_q.pop_front();
      check({tag, "_rise"},  32'(rise_pulse), 32'(e_r));
      check({tag, "_fall"},  32'(fall_pulse), 32'(e_f));
      check({tag, "_clean"}, 32'(clean_out),  32'(e_c));
`ifndef DEBOUNCE_EVENT_LATCH_EN
      check({tag, "_press"}, 32'(press_latched), 32'(0));
`endif
    end
  endtask

  initial begin
    n_checks  = 0;
    n_pass    = 0;
    reset_n   = 1'b0;
    raw_in    = 11'h001;
    latch_clr = '0;

    // 1. Reset state, then 20 idle cycles with the button released.
    #1;
    check("rst_clean", 32'(clean_out),     32'(0));
    check("rst_rise",  32'(rise_pulse),    32'(0));
    check("rst_fall",  32'(fall_pulse),    32'(0));
    check("rst_press", 32'(press_latched), 32'(0));
    repeat (3) step();
    reset_n = 1'b1;
    expect_window("s1_idle", 20, 0, '0, '0, '0, '0);

    // 2. Active-low button press and release, each accepted 6 edges later.
    raw_in = 11'h000;
    expect_window("s2_press", 8, 6, 11'h001, '0, 11'h000, 11'h001);
    raw_in = 11'h001;
    expect_window("s2_release", 8, 6, '0, 11'h001, 11'h001, 11'h000);

    // 3. SW bit 3 bounces 1,0,1,0 for 2 cycles each. No count reaches 3,
    //    so the bounce produces no event.
    raw_in = 11'h009; expect_window("s3_b1", 2, 0, '0, '0, '0, '0);
    raw_in = 11'h001; expect_window("s3_b2", 2, 0, '0, '0, '0, '0);
    raw_in = 11'h009; expect_window("s3_b3", 2, 0, '0, '0, '0, '0);
    raw_in = 11'h001; expect_window("s3_b4", 2, 0, '0, '0, '0, '0);
    raw_in = 11'h009;
    expect_window("s3_settle", 8, 6, 11'h008, '0, 11'h000, 11'h008);

    // 4. Return to idle, then all switches go high on the same edge.
    raw_in = 11'h001;
    expect_window("s4_clear", 8, 6, '0, 11'h008, 11'h008, 11'h000);
    raw_in = 11'h7FF;
    expect_window("s4_all", 8, 6, 11'h7FE, '0, 11'h000, 11'h7FE);

    // Async reset while clean_out is high forces it to 0 with no edge.
    reset_n = 1'b0;
    raw_in  = 11'h001;
    #1;
    check("s4_async_clean", 32'(clean_out), 32'(0));
    expect_window("s4_in_rst", 2, 0, '0, '0, '0, '0);
    reset_n = 1'b1;
    expect_window("s4_post_rst", 8, 0, '0, '0, '0, '0);

    // 5. SW bit 5 rises. Reset hits at count 2 (4 edges in), then
    //    requalification completes 6 edges after release.
    raw_in = 11'h021;
    expect_window("s5_qual", 4, 0, '0, '0, '0, '0);
    reset_n = 1'b0;
    #1;
    check("s5_rst_clean", 32'(clean_out),  32'(0));
    check("s5_rst_rise",  32'(rise_pulse), 32'(0));
    expect_window("s5_in_rst", 2, 0, '0, '0, '0, '0);
    reset_n = 1'b1;
    expect_window("s5_requal", 8, 6, 11'h020, '0, 11'h000, 11'h020);
    raw_in = 11'h001;
    expect_window("s5_drop", 8, 6, '0, 11'h020, 11'h020, 11'h000);

    // 6. Sticky press latch on channel 2.
`ifdef DEBOUNCE_EVENT_LATCH_EN
    latch_clr = '1;
    step();
    latch_clr = '0;
    check("s6_clr_all", 32'(press_latched), 32'(0));
    raw_in = 11'h005;
    expect_window("s6_rise", 6, 6, 11'h004, '0, 11'h000, 11'h004);
    step();
    check("s6_set", 32'(press_latched), 32'(11'h004));
    repeat (3) step();
    check("s6_hold", 32'(press_latched), 32'(11'h004));
    latch_clr = 11'h004;
    step();
    latch_clr = '0;
    check("s6_cleared", 32'(press_latched), 32'(0));
    raw_in = 11'h001;
    expect_window("s6_fall", 8, 6, '0, 11'h004, 11'h004, 11'h000);
    check("s6_no_set_on_fall", 32'(press_latched), 32'(0));
    raw_in = 11'h005;
    expect_window("s6_rise2", 6, 6, 11'h004, '0, 11'h000, 11'h004);
    latch_clr = 11'h004;
    step();
    latch_clr = '0;
    check("s6_set_wins", 32'(press_latched), 32'(11'h004));
    step();
    check("s6_set_wins_hold", 32'(press_latched), 32'(11'h004));
`else
    latch_clr = '1;
    raw_in    = 11'h005;
    expect_window("s6_nolatch", 8, 6, 11'h004, '0, 11'h000, 11'h004);
    latch_clr = '0;
    check("s6_press_zero", 32'(press_latched), 32'(0));
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
